// File: rtl/vlc_bit_packer.sv
// Packs right-justified variable-length codes into dense OUTPUT_WIDTH words, LSB first.
// Flush emits the residue padded with PAD_BIT and tagged last; overflow+flush defers it one cycle.
module vlc_bit_packer #(
    parameter int       OUTPUT_WIDTH = 32,
    parameter int       LENGTH_WIDTH = 6,
    parameter logic     PAD_BIT      = 1'b1
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    data_in_valid,
    input  logic [OUTPUT_WIDTH-1:0] data_in,
    input  logic [LENGTH_WIDTH-1:0] data_in_length,
    input  logic                    flush,
    output logic                    data_out_valid,
    output logic [OUTPUT_WIDTH-1:0] data_out,
    output logic                    data_out_last
);
    localparam int                  W   = OUTPUT_WIDTH;
    localparam logic [LENGTH_WIDTH-1:0] W_L = LENGTH_WIDTH'(OUTPUT_WIDTH);
    localparam logic [LENGTH_WIDTH:0]   W_S = (LENGTH_WIDTH+1)'(OUTPUT_WIDTH);

    logic [2*W-1:0]          acc_q, acc_d;
    logic [LENGTH_WIDTH-1:0] fill_q, fill_d;
    logic                    pend_q, pend_d;
    logic                    vld_q, vld_d;
    logic [W-1:0]            out_q, out_d;
    logic                    last_q, last_d;

    logic [LENGTH_WIDTH-1:0] len_c;
    logic [2*W-1:0]          code_c;
    logic [2*W-1:0]          acc_n;
    logic [LENGTH_WIDTH:0]   sum_n;

    // Bits at and above f are replaced with PAD_BIT; f is 1..W-1 when used.
    function automatic logic [W-1:0] pad_word(input logic [W-1:0] w, input logic [LENGTH_WIDTH:0] f);
        logic [W-1:0] keep;
        keep = {W{1'b1}} >> (W_S - f);
        return PAD_BIT ? (w | ~keep) : (w & keep);
    endfunction

    always_comb begin
        len_c  = (data_in_length > W_L) ? W_L : data_in_length;
        code_c = {{W{1'b0}}, data_in} & ({{W{1'b0}}, {W{1'b1}}} >> (W_L - len_c));

        acc_d  = acc_q;
        fill_d = fill_q;
        pend_d = 1'b0;
        vld_d  = 1'b0;
        out_d  = out_q;
        last_d = 1'b0;
        acc_n  = acc_q;
        sum_n  = {1'b0, fill_q};

        if (pend_q) begin
            if (fill_q != '0) begin
                vld_d  = 1'b1;
                out_d  = pad_word(acc_q[W-1:0], {1'b0, fill_q});
                last_d = 1'b1;
            end
            acc_d  = '0;
            fill_d = '0;
        end else begin
            if (data_in_valid && len_c != '0) begin
                acc_n = acc_q | (code_c << fill_q);
                sum_n = {1'b0, fill_q} + {1'b0, len_c};
            end
            if (sum_n >= W_S) begin
                vld_d  = 1'b1;
                out_d  = acc_n[W-1:0];
                acc_n  = acc_n >> W;
                sum_n  = sum_n - W_S;
                pend_d = flush;
            end else if (flush) begin
                if (sum_n != '0) begin
                    vld_d  = 1'b1;
                    out_d  = pad_word(acc_n[W-1:0], sum_n);
                    last_d = 1'b1;
                end
                acc_n = '0;
                sum_n = '0;
            end
            acc_d  = acc_n;
            fill_d = sum_n[LENGTH_WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            acc_q  <= '0;
            fill_q <= '0;
            pend_q <= 1'b0;
            vld_q  <= 1'b0;
            out_q  <= '0;
            last_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
            pend_q <= pend_d;
            vld_q  <= vld_d;
            out_q  <= out_d;
            last_q <= last_d;
        end
    end

    assign data_out_valid = vld_q;
    assign data_out       = out_q;
    assign data_out_last  = last_q;
endmodule

// File: tb/tb_vlc_bit_packer.sv
// Directed and random checks of vlc_bit_packer against a bit-queue reference model.
module tb_vlc_bit_packer;
    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic        data_in_valid = 1'b0;
    logic [31:0] data_in = '0;
    logic [5:0]  data_in_length = '0;
    logic        flush = 1'b0;
    logic        data_out_valid;
    logic [31:0] data_out;
    logic        data_out_last;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    bit   bq[$];
    int   errors = 0;
    int   checks = 0;

    vlc_bit_packer #(.OUTPUT_WIDTH(32), .LENGTH_WIDTH(6), .PAD_BIT(1'b1)) dut (
        .clock(clock), .nreset(nreset),
        .data_in_valid(data_in_valid), .data_in(data_in), .data_in_length(data_in_length),
        .flush(flush),
        .data_out_valid(data_out_valid), .data_out(data_out), .data_out_last(data_out_last)
    );

    always #5 clock = ~clock;

    // Reference: an explicit FIFO of bits; every 32 bits popped form a word.
    task automatic model(input logic v, input logic [31:0] d, input logic [5:0] l, input logic f);
        int   len;
        exp_t e;
        len = (l > 6'd32) ? 32 : int'(l);
        if (v) for (int i = 0; i < len; i++) bq.push_back(d[i]);
        if (bq.size() >= 32) begin
            for (int i = 0; i < 32; i++) e.data[i] = bq.pop_front();
            e.last = 1'b0;
            sb.push_back(e);
        end
        if (f && bq.size() > 0) begin
            for (int i = 0; i < 32; i++) e.data[i] = (bq.size() > 0) ? bq.pop_front() : 1'b1;
            e.last = 1'b1;
            sb.push_back(e);
        end
        if (f) bq.delete();
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic [5:0] l, input logic f);
        model(v, d, l, f);
        data_in_valid  = v;
        data_in        = d;
        data_in_length = l;
        flush          = f;
        @(posedge clock);
        #1;
        data_in_valid  = 1'b0;
        data_in        = '0;
        data_in_length = '0;
        flush          = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (nreset && data_out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $error("FAIL unexpected_word observed=%h last=%0b expected=none", data_out, data_out_last);
            end else begin
                exp_t e;
                e = sb.pop_front();
                assert ({data_out, data_out_last} === {e.data, e.last}) else begin
                    errors++;
                    $error("FAIL word observed=%h/%0b expected=%h/%0b", data_out, data_out_last, e.data, e.last);
                end
            end
        end
    end

    initial begin
        int ncodes;
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", {31'b0, data_out_valid}, 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_last", {31'b0, data_out_last}, 32'd0);
        @(negedge clock);
        nreset = 1'b1;

        // Full-width code at fill 0
        step(1'b1, 32'hDEADBEEF, 6'd32, 1'b0);
        chk("full_code_valid", {31'b0, data_out_valid}, 32'd1);
        step(1'b0, '0, '0, 1'b0);
        chk("full_code_idle", {31'b0, data_out_valid}, 32'd0);

        // Mid-word async reset with fill 12 discards residue
        step(1'b1, 32'h00000FFF, 6'd12, 1'b0);
        #2 nreset = 1'b0;
        bq.delete();
        #1;
        chk("midrst_valid", {31'b0, data_out_valid}, 32'd0);
        chk("midrst_data", data_out, 32'd0);
        chk("midrst_last", {31'b0, data_out_last}, 32'd0);
        @(negedge clock);
        nreset = 1'b1;

        // Eight nibbles -> one word, valid right after the 8th
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 32'(i), 6'd4, 1'b0);
            chk("nibble_valid", {31'b0, data_out_valid}, (i == 8) ? 32'd1 : 32'd0);
        end
        chk("nibble_data", data_out, 32'h87654321);

        // Straddle with garbage above the code length
        step(1'b1, 32'hFFFABCDE, 6'd20, 1'b0);
        step(1'b1, 32'hF5512345, 6'd20, 1'b0);
        chk("straddle_data", data_out, 32'h345ABCDE);

        // Flush residue, then flush on empty
        step(1'b0, '0, '0, 1'b1);
        chk("flush_valid", {31'b0, data_out_valid}, 32'd1);
        chk("flush_data", data_out, 32'hFFFFFF12);
        step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b1);
        chk("empty_flush_valid", {31'b0, data_out_valid}, 32'd0);
        step(1'b0, '0, '0, 1'b0);

        // Append+flush overflow: full word then deferred padded word
        step(1'b1, 32'h00000012, 6'd8, 1'b0);
        step(1'b1, 32'h0ABCDEF1, 6'd28, 1'b1);
        chk("ovf_word", data_out, 32'hBCDEF112);
        chk("ovf_last", {31'b0, data_out_last}, 32'd0);
        step(1'b0, '0, '0, 1'b0);
        chk("pend_word", data_out, 32'hFFFFFFFA);
        chk("pend_last", {31'b0, data_out_last}, 32'd1);
        step(1'b0, '0, '0, 1'b0);
        chk("pend_done", {31'b0, data_out_valid}, 32'd0);

        // Zero length is a no-op; oversize length clamps to 32
        step(1'b1, 32'hFFFFFFFF, 6'd0, 1'b0);
        chk("zero_len", {31'b0, data_out_valid}, 32'd0);
        step(1'b1, 32'hCAFEF00D, 6'd63, 1'b0);
        chk("clamp_data", data_out, 32'hCAFEF00D);

        // Random codes with occasional flushes, always followed by an idle cycle
        ncodes = 400;
        for (int i = 0; i < ncodes; i++) begin
            logic f;
            logic [5:0] l;
            f = ($urandom_range(0, 15) == 0);
            l = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(33, 63)) : 6'($urandom_range(0, 32));
            step(1'b1, $urandom, l, f);
            if (f) step(1'b0, '0, '0, 1'b0);
        end
        step(1'b0, '0, '0, 1'b1);
        repeat (4) step(1'b0, '0, '0, 1'b0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/vlc_bit_packer.md
# vlc_bit_packer

Packs variable-length entropy codes (1–32 bits each) into a dense stream of fixed-width words. The first code bit lands in bit 0 of the first output word. It sits directly upstream of `width_adapter_buffer` and drives that block's `data_in_valid`/`data_in` pair. The output is valid-only with no backpressure, matching the adapter's input contract. A flush request pads and emits the final partial word at end of scan.

## Interface
- `OUTPUT_WIDTH`, 32, output word width; a code is never longer than this.
- `LENGTH_WIDTH`, 6, width of the length field; must hold `OUTPUT_WIDTH`.
- `PAD_BIT`, 1'b1, value of the fill bits used by flush (JPEG pads with 1s).
- `clock`  input  1  sole clock; all state changes on its rising edge.
- `nreset`  input  1  reset, asynchronous, active-low.
- `data_in_valid`  input  1  `data_in`/`data_in_length` are presented this cycle.
- `data_in`  input  OUTPUT_WIDTH  code bits, right-justified; bits at or above `data_in_length` are ignored (masked).
- `data_in_length`  input  LENGTH_WIDTH  number of valid code bits, 0..OUTPUT_WIDTH.
- `flush`  input  1  single-cycle request to emit any residual bits as a padded final word.
- `data_out_valid`  output  1  `data_out` holds a packed word this cycle.
- `data_out`  output  OUTPUT_WIDTH  packed word; earliest bit in bit 0.
- `data_out_last`  output  1  qualifies `data_out_valid`; set on the word produced by a flush.

## Operation
- State:
  - accumulator `acc` of 2*OUTPUT_WIDTH bits;
  - `fill` count 0..OUTPUT_WIDTH-1 (valid bits held in `acc` LSBs);
  - `flush_pending` flag.
- Append: on `data_in_valid` with length L > 0, the masked code is OR'd into `acc` at bit position `fill`, and `fill + L` is computed.
  - If `fill + L >= OUTPUT_WIDTH`: `acc[OUTPUT_WIDTH-1:0]` is emitted. `acc` shifts right by OUTPUT_WIDTH. `fill` becomes `fill + L - OUTPUT_WIDTH`.
  - Otherwise `fill` becomes `fill + L` and nothing is emitted.
- L = 0 with valid: no state change, no output.
- L > OUTPUT_WIDTH is illegal and is clamped to OUTPUT_WIDTH.
- Flush, no simultaneous overflow: the word `acc[OUTPUT_WIDTH-1:0]` is emitted with bits `[OUTPUT_WIDTH-1:fill']` forced to PAD_BIT, where `fill'` includes any same-cycle append.
  - `data_out_last` is 1.
  - `fill` and `acc` are cleared.
- Flush with `fill' == 0`: no word is emitted, and no last marker is produced.
- Flush in the same cycle as an append that overflows:
  - The full word is emitted this cycle with `last` = 0.
  - `flush_pending` is set.
  - On the next cycle the residue is emitted padded with `last` = 1, or nothing is emitted if the residue is 0 bits.
- Input while `flush_pending` is set is illegal; upstream guarantees at least one idle cycle after a flush.
- At most one word is emitted per cycle, so full 1-code/cycle input rate is sustained with no stalls.

## Timing
- Reset (`nreset` low, asynchronous): `data_out_valid` = 0, `data_out` = 0, `data_out_last` = 0, `fill` = 0, `acc` = 0, `flush_pending` = 0.
- Reset mid-word discards residual bits without emitting them.
- Outputs are registered. A word triggered by the input on edge N is valid for exactly one cycle after edge N.
- A pending-flush word appears one cycle after the overflow word.
- `data_out_valid` is a single-cycle pulse per word. `data_out` holds its value when not valid; downstream must not sample it then.
- Sustained throughput: `OUTPUT_WIDTH` bits/cycle peak. Downstream rate matching is the adapter's job.

## Test plan
- Reset: hold `nreset` low mid-stream with `fill` = 12 -> all outputs 0. After release, the first word contains no stale bits.
- Eight consecutive 4-bit codes 0x1..0x8 -> exactly one word 0x87654321, valid the cycle after the 8th input, `last` = 0.
- 32-bit code 0xDEADBEEF at `fill` 0 -> 0xDEADBEEF next cycle; `fill` stays 0.
- Straddle: 20-bit 0xABCDE, then 20-bit 0x12345 (upper garbage bits set in `data_in`) -> word 0x345ABCDE; residual `fill` = 8, holding 0x12.
- Flush: from residual 0x12 (`fill` 8), pulse `flush` -> 0xFFFFFF12 with `last` = 1. A second flush with `fill` 0 -> no output.
- Append and flush together: `fill` 8 holding 0x12, then 28-bit code 0xABCDEF1 with `flush` -> 0xCDEF1 12 packed as 0xCDEF1120? No: the exact required words are 0xBCDEF112 (`last` = 0), then the next cycle 0xFFFFFFFA (`last` = 1). Also randomized runs through `width_adapter_buffer` compare the nibble stream to a bit-exact reference model.
